// File: rtl/xlr8_dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   owner_e       : which master a RAM read issued on the last edge belongs to
//   dm_adr_width  : RAM address width for a given RAM size in KB, the same
//                   ceil-log2 rule the RAM itself uses to size its array
package xlr8_dm_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_XB   = 2'd2
  } owner_e;

  function automatic int unsigned dm_adr_width(input int unsigned size_kb);
    return $clog2(size_kb * 1024);
  endfunction

endpackage

// File: rtl/xlr8_dm_arb.sv
// Two-master arbiter in front of the single-port data-memory RAM.
// The AVR core (CPU) has fixed priority over the XB accelerator. A starvation
// counter forces an XB grant after MAX_WAIT consecutive denied cycles, stalling
// the CPU for that one cycle. RAM read data (one-cycle latency) is steered back
// to whichever master issued the read.
//
// Ports:
//   cp2, ireset                 clock, asynchronous active-low reset
//   cpu_adr/re/we/dout          CPU data-space access; cpu_din read data back
//   cpuwait                     CPU stall (combinational)
//   xb_req/we/adr/wdata         XB request, held until xb_gnt
//   xb_gnt                      XB grant (combinational), request done this edge
//   xb_rvalid, xb_rdata         XB read data, the cycle after the grant
//   dm_ce/adr/din/we, dm_dout   RAM port (RAM-relative addresses)
module xlr8_dm_arb
  import xlr8_dm_arb_pkg::*;
#(
  parameter logic [15:0] DM_START = 16'h0100,
  parameter int          DM_SIZE  = 2,
  parameter int          MAX_WAIT = 4
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpuwait,
  input  logic        xb_req,
  input  logic        xb_we,
  input  logic [15:0] xb_adr,
  input  logic [7:0]  xb_wdata,
  output logic        xb_gnt,
  output logic        xb_rvalid,
  output logic [7:0]  xb_rdata,
  output logic        dm_ce,
  output logic [15:0] dm_adr,
  output logic [7:0]  dm_din,
  output logic        dm_we,
  input  logic [7:0]  dm_dout
);

  // Window bounds in 17 bits so a window ending exactly at 64K does not wrap.
  localparam logic [16:0] WIN_LO     = {1'b0, DM_START};
  localparam logic [16:0] WIN_HI     = WIN_LO + 17'(DM_SIZE * 1024);
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_q, wait_d;
  owner_e      owner_q, owner_d;
  logic [15:0] dm_adr_q, dm_adr_d;

  logic cpu_hit;
  logic force_xb;
  logic gnt;
  logic cpu_sel;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    cpu_hit  = 1'b0;
    force_xb = 1'b0;
    gnt      = 1'b0;
    cpu_sel  = 1'b0;
    wait_d   = 4'd0;
    owner_d  = OWN_NONE;
    dm_adr_d = dm_adr_q;

    cpu_hit  = (cpu_re | cpu_we) &&
               ({1'b0, cpu_adr} >= WIN_LO) && ({1'b0, cpu_adr} < WIN_HI);
    force_xb = xb_req && (wait_q == MAX_WAIT_C);
    gnt      = xb_req && (force_xb || !cpu_hit);
    cpu_sel  = cpu_hit && !force_xb;

    // Idle cycles keep the last address on the RAM port.
    if (cpu_sel) begin
      dm_adr_d = cpu_adr - DM_START;
    end else if (gnt) begin
      dm_adr_d = xb_adr;
    end

    // Saturating count of consecutive denied XB cycles.
    if (xb_req && !gnt) begin
      wait_d = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + 4'd1;
    end

    // cpu_sel and gnt are mutually exclusive, so at most one read is live.
    if (cpu_sel && cpu_re) begin
      owner_d = OWN_CPU;
    end else if (gnt && !xb_we) begin
      owner_d = OWN_XB;
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      wait_q   <= 4'd0;
      owner_q  <= OWN_NONE;
      dm_adr_q <= 16'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      wait_q   <= wait_d;
      owner_q  <= owner_d;
      dm_adr_q <= dm_adr_d;
    end
  end

  // Combinational outputs are gated by the reset so the RAM port and the
  // grants are quiet for the whole time ireset is asserted.
  always_comb begin
    cpu_din   = 8'h00;
    cpuwait   = 1'b0;
    xb_gnt    = 1'b0;
    xb_rvalid = 1'b0;
    xb_rdata  = 8'h00;
    dm_ce     = 1'b0;
    dm_adr    = 16'h0000;
    dm_din    = 8'h00;
    dm_we     = 1'b0;

    if (ireset) begin
      cpuwait = force_xb && cpu_hit;
      xb_gnt  = gnt;
      dm_ce   = cpu_hit || xb_req;
      dm_adr  = dm_adr_d;
      if (cpu_sel) begin
        dm_din = cpu_dout;
        dm_we  = cpu_we;
      end else if (gnt) begin
        dm_din = xb_wdata;
        dm_we  = xb_we;
      end
    end

    if (owner_q == OWN_CPU) begin
      cpu_din = dm_dout;
    end else if (owner_q == OWN_XB) begin
      xb_rvalid = 1'b1;
      xb_rdata  = dm_dout;
    end
  end

endmodule

// File: tb/tb_xlr8_dm_arb.sv
module tb_xlr8_dm_arb;

  localparam int DM_START = 16'h0100;
  localparam int DM_SIZE  = 2;
  localparam int MAX_WAIT = 4;
  localparam int RAM_SZ   = DM_SIZE * 1024;

  logic        cp2;
  logic        ireset;
  logic [15:0] cpu_adr;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpuwait;
  logic        xb_req, xb_we;
  logic [15:0] xb_adr;
  logic [7:0]  xb_wdata;
  logic        xb_gnt, xb_rvalid;
  logic [7:0]  xb_rdata;
  logic        dm_ce;
  logic [15:0] dm_adr;
  logic [7:0]  dm_din;
  logic        dm_we;
  logic [7:0]  dm_dout;

  int total = 0;
  int bad   = 0;

  xlr8_dm_arb #(.DM_START(16'h0100), .DM_SIZE(DM_SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .cp2(cp2), .ireset(ireset),
    .cpu_adr(cpu_adr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpuwait(cpuwait),
    .xb_req(xb_req), .xb_we(xb_we), .xb_adr(xb_adr), .xb_wdata(xb_wdata),
    .xb_gnt(xb_gnt), .xb_rvalid(xb_rvalid), .xb_rdata(xb_rdata),
    .dm_ce(dm_ce), .dm_adr(dm_adr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;

  // RAM stub: read-first, one-cycle latency, truncates the address.
  logic [7:0] ram [0:RAM_SZ-1];
  always @(posedge cp2) begin
    if (dm_ce) begin
      if (dm_we) ram[dm_adr[10:0]] <= dm_din;
      dm_dout <= ram[dm_adr[10:0]];
    end
  end

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 13) + 7);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected RAM contents plus the handful of facts the rules depend on:
  // how long XB has been refused, and who gets the data back next cycle.
  logic [7:0]  mm [0:RAM_SZ-1];
  int          m_wait;
  int          m_pend;      // 0 none, 1 CPU, 2 XB
  logic [7:0]  m_pdata;
  logic [15:0] m_last;
  bit          m_hit, m_frc, m_gnt, m_sel, m_stall;

  task automatic model_reset();
    m_wait = 0; m_pend = 0; m_pdata = 8'h00; m_last = 16'h0000;
  endtask

  task automatic model_eval();
    int a;
    a      = int'(cpu_adr);
    m_hit  = (cpu_re || cpu_we) && a >= DM_START && a < DM_START + RAM_SZ;
    m_frc  = xb_req && (m_wait >= MAX_WAIT);
    m_gnt  = xb_req && (m_frc || !m_hit);
    m_sel  = m_hit && !m_frc;
    m_stall = m_hit && m_frc;
  endtask

  task automatic model_check();
    logic [15:0] eadr;
    eadr = m_sel ? 16'(int'(cpu_adr) - DM_START) : (m_gnt ? xb_adr : m_last);
    check("m_gnt", xb_gnt, m_gnt);
    check("m_cpuwait", cpuwait, m_stall);
    check("m_ce", dm_ce, m_hit || xb_req);
    check("m_we", dm_we, m_sel ? cpu_we : (m_gnt ? xb_we : 1'b0));
    check("m_adr", dm_adr, eadr);
    if (m_sel) check("m_din_cpu", dm_din, cpu_dout);
    else if (m_gnt) check("m_din_xb", dm_din, xb_wdata);
    check("m_cpu_din", cpu_din, (m_pend == 1) ? m_pdata : 8'h00);
    check("m_rvalid", xb_rvalid, m_pend == 2);
    check("m_rdata", xb_rdata, (m_pend == 2) ? m_pdata : 8'h00);
  endtask

  task automatic model_update();
    int idx;
    m_pend = 0;
    if (m_sel) begin
      idx = int'(cpu_adr) - DM_START;
      if (cpu_re) begin m_pend = 1; m_pdata = mm[idx]; end
      if (cpu_we) mm[idx] = cpu_dout;
      m_last = 16'(idx);
    end else if (m_gnt) begin
      idx = int'(xb_adr[10:0]);
      if (!xb_we) begin m_pend = 2; m_pdata = mm[idx]; end
      else mm[idx] = xb_wdata;
      m_last = xb_adr;
    end
    if (xb_req && !m_gnt) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
    else m_wait = 0;
  endtask

  task automatic settle();
    @(negedge cp2);
    model_eval();
    model_check();
  endtask

  task automatic tick();
    @(posedge cp2);
    model_update();
    #1;
  endtask

  task automatic set_cpu(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_re = re; cpu_we = we; cpu_adr = a; cpu_dout = d;
  endtask

  task automatic set_xb(input logic rq, input logic we, input logic [15:0] a, input logic [7:0] d);
    xb_req = rq; xb_we = we; xb_adr = a; xb_wdata = d;
  endtask

  task automatic idle();
    set_cpu(0, 0, 16'h0000, 8'h00);
    set_xb(0, 0, 16'h0000, 8'h00);
    settle(); tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] cpu_adr;
    logic        re, we;
    logic        xb_req, xb_we;
    logic [15:0] xb_adr;
    logic        gnt, ce, dwe;
    logic        chk_adr;
    logic [15:0] adr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int wd_ok;
    ireset = 1'b0;
    set_cpu(0, 0, 16'h0000, 8'h00);
    set_xb(0, 0, 16'h0000, 8'h00);
    for (int i = 0; i < RAM_SZ; i++) begin
      ram[i] = pat(i);
      mm[i]  = pat(i);
    end
    model_reset();

    vecs[0] = '{16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[1] = '{16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{16'h08FF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h07FF};
    vecs[3] = '{16'h0900, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{16'h0200, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100};
    vecs[5] = '{16'h0200, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005};
    vecs[6] = '{16'h0900, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0123};
    vecs[7] = '{16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[9] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h07FF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h07FF};

    // Reset state.
    repeat (2) @(posedge cp2);
    @(negedge cp2);
    check("rst_gnt", xb_gnt, 1'b0);
    check("rst_rvalid", xb_rvalid, 1'b0);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_ce", dm_ce, 1'b0);
    check("rst_adr", dm_adr, 16'h0000);
    check("rst_we", dm_we, 1'b0);
    @(posedge cp2); #1;
    ireset = 1'b1;

    // XB read with CPU idle: granted now, data next cycle.
    set_xb(1, 0, 16'h0010, 8'h00);
    settle();
    check("xbrd_gnt", xb_gnt, 1'b1);
    tick();
    set_xb(0, 0, 16'h0000, 8'h00);
    settle();
    check("xbrd_rvalid", xb_rvalid, 1'b1);
    check("xbrd_rdata", xb_rdata, pat(16));
    tick();

    // Simultaneous writes: CPU wins, XB follows on the next idle cycle.
    set_cpu(0, 1, 16'h0110, 8'hA5);
    set_xb(1, 1, 16'h0010, 8'h3C);
    settle();
    check("cw_gnt", xb_gnt, 1'b0);
    check("cw_adr", dm_adr, 16'h0010);
    check("cw_din", dm_din, 8'hA5);
    tick();
    check("cw_ram_a5", ram[16], 8'hA5);
    set_cpu(0, 0, 16'h0000, 8'h00);
    settle();
    check("cw_xb_gnt", xb_gnt, 1'b1);
    check("cw_xb_din", dm_din, 8'h3C);
    tick();
    check("cw_ram_3c", ram[16], 8'h3C);
    idle();

    // Table of single-cycle vectors, each from a cleared counter.
    foreach (vecs[i]) begin
      set_cpu(vecs[i].re, vecs[i].we, vecs[i].cpu_adr, 8'(8'h11 * i));
      set_xb(vecs[i].xb_req, vecs[i].xb_we, vecs[i].xb_adr, 8'(8'hC0 + i));
      settle();
      check($sformatf("vec%0d_gnt", i), xb_gnt, vecs[i].gnt);
      check($sformatf("vec%0d_ce", i), dm_ce, vecs[i].ce);
      check($sformatf("vec%0d_we", i), dm_we, vecs[i].dwe);
      if (vecs[i].chk_adr) check($sformatf("vec%0d_adr", i), dm_adr, vecs[i].adr);
      tick();
      idle();
    end

    // Starvation: CPU keeps reading in-window, XB read held.
    set_cpu(1, 0, 16'h0130, 8'h00);
    set_xb(1, 0, 16'h0020, 8'h00);
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("starve%0d_gnt", k), xb_gnt, 1'b0);
      check($sformatf("starve%0d_wait", k), cpuwait, 1'b0);
      tick();
    end
    settle();
    check("force_gnt", xb_gnt, 1'b1);
    check("force_cpuwait", cpuwait, 1'b1);
    check("force_adr", dm_adr, 16'h0020);
    tick();
    set_xb(0, 0, 16'h0000, 8'h00);
    settle();
    check("after_cpuwait", cpuwait, 1'b0);
    check("after_adr", dm_adr, 16'h0030);
    check("after_rvalid", xb_rvalid, 1'b1);
    check("after_rdata", xb_rdata, pat(32));
    tick();
    set_cpu(0, 0, 16'h0000, 8'h00);
    settle();
    check("cpu_rd_done", cpu_din, pat(48));
    check("cpu_rd_rvalid", xb_rvalid, 1'b0);
    tick();

    // Out-of-window CPU read never conflicts.
    set_cpu(1, 0, 16'h0050, 8'h00);
    set_xb(1, 0, 16'h0040, 8'h00);
    settle();
    check("oow_gnt", xb_gnt, 1'b1);
    check("oow_cpuwait", cpuwait, 1'b0);
    tick();
    set_cpu(0, 0, 16'h0000, 8'h00);
    set_xb(0, 0, 16'h0000, 8'h00);
    settle();
    check("oow_cpu_din", cpu_din, 8'h00);
    check("oow_rdata", xb_rdata, pat(64));
    tick();

    // Reset in the cycle after an XB read grant.
    set_xb(1, 0, 16'h0060, 8'h00);
    settle();
    check("mid_gnt", xb_gnt, 1'b1);
    tick();
    ireset = 1'b0;
    set_cpu(1, 0, 16'h0140, 8'h00);
    set_xb(1, 0, 16'h0061, 8'h00);
    @(negedge cp2);
    check("mid_rvalid", xb_rvalid, 1'b0);
    check("mid_rdata", xb_rdata, 8'h00);
    check("mid_cpu_din", cpu_din, 8'h00);
    check("mid_cpuwait", cpuwait, 1'b0);
    check("mid_xb_gnt", xb_gnt, 1'b0);
    check("mid_ce", dm_ce, 1'b0);
    check("mid_adr", dm_adr, 16'h0000);
    check("mid_din", dm_din, 8'h00);
    check("mid_we", dm_we, 1'b0);
    @(posedge cp2); #1;
    check("mid_rvalid2", xb_rvalid, 1'b0);
    ireset = 1'b1;
    model_reset();
    // A cleared counter means exactly MAX_WAIT denials before the force.
    for (int k = 0; k <= MAX_WAIT; k++) begin
      settle();
      check($sformatf("rel%0d_gnt", k), xb_gnt, k == MAX_WAIT);
      tick();
    end
    idle();

    // Randomised traffic against the model, respecting both masters' rules:
    // a stalled CPU repeats its access, a refused XB request is held.
    wd_ok = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!m_stall) begin
        case ($urandom_range(0, 2))
          0: set_cpu(0, 0, 16'($urandom_range(0, 16'hFFFF)), 8'($urandom));
          1: set_cpu(1, 0, 16'($urandom_range(16'h00F0, 16'h0910)), 8'($urandom));
          default: set_cpu(0, 1, 16'($urandom_range(16'h00F0, 16'h0910)), 8'($urandom));
        endcase
      end
      if (!(xb_req && !m_gnt)) begin
        if ($urandom_range(0, 1) == 1)
          set_xb(1, 1'($urandom), 16'($urandom), 8'($urandom));
        else
          set_xb(0, 0, 16'h0000, 8'h00);
      end
      settle();
      if (m_frc) wd_ok++;
      tick();
    end
    check("rand_forced_seen", (wd_ok > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xlr8_dm_arb.md
# xlr8_dm_arb

Two-master access arbiter directly upstream of the data-memory RAM. Merges AVR core data-space accesses with byte requests from an XB accelerator onto the single RAM port. CPU has fixed priority; a starvation counter forces an accelerator grant by stalling the CPU for one cycle. Read data from the RAM's one-cycle-latency output is steered back to the master that issued the read.

## Interface
Parameters:
- DM_START, 16'h0100, first CPU data-space address mapped to RAM.
- DM_SIZE, 2, RAM size in KB (1..64). Mapped window is [DM_START, DM_START + DM_SIZE*1024).
- MAX_WAIT, 4, consecutive denied XB cycles before a forced grant (1..15).

Ports:
- cp2  in  1  clock; all state on the rising edge.
- ireset  in  1  asynchronous, active-low reset.
- cpu_adr  in  16  CPU data-space address.
- cpu_re  in  1  CPU read strobe.
- cpu_we  in  1  CPU write strobe.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  read data to CPU.
- cpuwait  out  1  CPU stall, combinational.
- xb_req  in  1  XB access request, held until granted.
- xb_we  in  1  XB write (1) or read (0), qualified by xb_req.
- xb_adr  in  16  XB RAM-relative byte address.
- xb_wdata  in  8  XB write data.
- xb_gnt  out  1  XB grant, combinational; the request completes on this edge.
- xb_rvalid  out  1  XB read data valid.
- xb_rdata  out  8  XB read data.
- dm_ce  out  1  RAM clock enable.
- dm_adr  out  16  RAM address, RAM-relative.
- dm_din  out  8  RAM write data.
- dm_we  out  1  RAM write enable.
- dm_dout  in  8  RAM read data, valid the cycle after the address edge.

## Operation
- cpu_hit = (cpu_re | cpu_we) & cpu_adr within the window. The window check uses 17-bit arithmetic so a window ending at 64K does not wrap.
- Forced state: force = xb_req & (wait_cnt == MAX_WAIT).
- Grant:
  - Not forced: xb_gnt = xb_req & ~cpu_hit.
  - Forced: xb_gnt = 1, and cpuwait = cpu_hit.
- cpuwait is 0 at all other times.
- RAM mux:
  - CPU selected (cpu_hit & ~force): dm_adr = cpu_adr - DM_START, dm_din = cpu_dout, dm_we = cpu_we.
  - XB selected (xb_gnt): dm_adr = xb_adr, dm_din = xb_wdata, dm_we = xb_we.
  - Neither selected: dm_adr holds its last value and dm_we = 0.
  - dm_ce = cpu_hit | xb_req.
- Starvation counter wait_cnt, 4 bits:
  - Increments when xb_req & ~xb_gnt.
  - Clears on xb_gnt or ~xb_req.
  - Saturates at MAX_WAIT.
- Read tracking: a registered owner field {NONE, CPU, XB} is loaded each edge from the read selected that cycle, or NONE if there was no read.
  - owner == CPU: cpu_din = dm_dout.
  - owner == XB: xb_rvalid = 1 and xb_rdata = dm_dout.
  - Otherwise cpu_din and xb_rdata = 0 and xb_rvalid = 0.
- CPU accesses outside the window never touch the RAM and never conflict.
- XB addresses are truncated to the RAM address width by the RAM; no range check is done here.

## Timing
- Reset values: wait_cnt = 0, owner = NONE.
- Outputs during reset: cpu_din = 0, cpuwait = 0, xb_gnt = 0, xb_rvalid = 0, xb_rdata = 0, dm_ce = 0, dm_adr = 0, dm_din = 0, dm_we = 0.
- Write latency: 0 cycles. The RAM is written on the edge ending the selected cycle.
- Read latency: 1 cycle. Data and xb_rvalid are present in the cycle after the selecting edge.
- CPU stalled by cpuwait: the CPU keeps the same access presented. It is served the next cycle because wait_cnt clears on the forced grant.
- Worst-case XB wait: MAX_WAIT+1 cycles from request to grant.
- Back-to-back XB grants are allowed while the CPU is idle. xb_rvalid may then be high for consecutive cycles.
- Reset mid-operation: owner clears to NONE. No xb_rvalid is issued for a read in flight.

## Structure
- Shared package holds:
  - owner encoding constants: OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_XB = 2'd2;
  - the DM_SIZE-to-address-width function, matching the RAM's log2 rule.
- Single flat module; no sub-module is needed. The window compare and the counter are a few lines each.

## Test plan
- XB read at 0x0010 with the CPU idle: xb_gnt in the same cycle; next cycle xb_rvalid = 1 and xb_rdata = RAM[0x0010].
- CPU write 0xA5 to 0x0110 simultaneous with an XB write 0x3C to 0x0010 (DM_START = 0x0100): CPU wins, RAM[0x10] = 0xA5, xb_gnt = 0, wait_cnt = 1. XB is granted the next idle cycle, after which RAM[0x10] = 0x3C.
- CPU continuously reading in-window with MAX_WAIT = 4 and xb_req held: cycles 0–3 deny XB; on cycle 4 xb_gnt = 1 and cpuwait = 1. On cycle 5 cpuwait = 0 and the CPU read completes.
- CPU read at 0x0050, outside the window, with an XB read in the same cycle: XB is granted immediately and cpu_din = 0 next cycle.
- Window upper bound with DM_SIZE = 2: a CPU access at 0x08FF hits the RAM; one at 0x0900 does not.
- ireset asserted in the cycle after an XB read grant: xb_rvalid stays 0, all outputs are 0, and wait_cnt = 0 after release.
